// File: rtl/gr_wb_if.sv
// Writeback-stage bus: ALU result handshake, load return path, register-file
// write port and the decode interlock mask.
interface gr_wb_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd_n;
    logic [31:0] alu_wd;

    logic        load_valid;
    logic [4:0]  load_rd_n;
    logic [2:0]  load_funct3;
    logic [1:0]  load_addr_lo;
    logic [31:0] load_rdata;

    logic        rd;
    logic [4:0]  rd_n;
    logic [31:0] wd;
    logic [31:0] pend_mask;

    // Stage side.
    modport slave (
        input  alu_valid, alu_rd_n, alu_wd,
        input  load_valid, load_rd_n, load_funct3, load_addr_lo, load_rdata,
        output alu_ready, rd, rd_n, wd, pend_mask
    );

    // Producer / register-file side.
    modport master (
        output alu_valid, alu_rd_n, alu_wd,
        output load_valid, load_rd_n, load_funct3, load_addr_lo, load_rdata,
        input  alu_ready, rd, rd_n, wd, pend_mask
    );
endinterface

// File: rtl/gr_wb_stage.sv
// Writeback stage in front of the general-register file. Loads always win the
// write port; ALU results that lose are parked in a small in-order FIFO.
module gr_wb_stage #(
    parameter int DEPTH = 2
) (
    input  logic     clk_20M,
    input  logic     rst_n,
    gr_wb_if.slave   bus
);

    logic [4:0]  q_rd_n [DEPTH];
    logic [31:0] q_wd   [DEPTH];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  cnt;

    logic        rd_q;
    logic [4:0]  rd_n_q;
    logic [31:0] wd_q;

    logic        acc;
    logic        push;
    logic        pop;
    logic        sel_any;
    logic [4:0]  sel_rd_n;
    logic [31:0] sel_wd;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;
    logic [31:0] pend;

    // Ready depends only on the registered occupancy, never on the valids.
    assign bus.alu_ready = (cnt != 2'(DEPTH));
    assign acc           = bus.alu_valid & bus.alu_ready;

    // Extract and extend the returned load word according to funct3.
    always_comb begin
        ld_byte = 8'h00;
        case (bus.load_addr_lo)
            2'd0:    ld_byte = bus.load_rdata[7:0];
            2'd1:    ld_byte = bus.load_rdata[15:8];
            2'd2:    ld_byte = bus.load_rdata[23:16];
            default: ld_byte = bus.load_rdata[31:24];
        endcase
        ld_half = bus.load_addr_lo[1] ? bus.load_rdata[31:16] : bus.load_rdata[15:0];
        ld_fmt  = bus.load_rdata;
        case (bus.load_funct3)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_fmt = bus.load_rdata;
            3'b100:  ld_fmt = {24'h000000, ld_byte};
            3'b101:  ld_fmt = {16'h0000, ld_half};
            default: ld_fmt = bus.load_rdata;
        endcase
    end

    // Pick this cycle's writer: load, then FIFO head, then a direct ALU result.
    always_comb begin
        sel_any  = 1'b0;
        sel_rd_n = 5'd0;
        sel_wd   = 32'h0;
        push     = 1'b0;
        pop      = 1'b0;
        if (bus.load_valid) begin
            sel_any  = 1'b1;
            sel_rd_n = bus.load_rd_n;
            sel_wd   = ld_fmt;
            push     = acc;
        end else if (cnt != 2'd0) begin
            sel_any  = 1'b1;
            sel_rd_n = q_rd_n[rd_ptr];
            sel_wd   = q_wd[rd_ptr];
            pop      = 1'b1;
            push     = acc;
        end else if (acc) begin
            sel_any  = 1'b1;
            sel_rd_n = bus.alu_rd_n;
            sel_wd   = bus.alu_wd;
        end
    end

    // Destinations still waiting in the FIFO; x0 is never a hazard.
    always_comb begin
        pend = 32'h0;
        if (cnt != 2'd0) begin
            pend[q_rd_n[rd_ptr]] = 1'b1;
        end
        if (cnt == 2'd2) begin
            pend[q_rd_n[~rd_ptr]] = 1'b1;
        end
        pend[0] = 1'b0;
    end

    assign bus.pend_mask = pend;

    // FIFO storage; contents are don't-care after reset so no reset here.
    always_ff @(posedge clk_20M) begin
        if (push) begin
            q_rd_n[wr_ptr] <= bus.alu_rd_n;
            q_wd[wr_ptr]   <= bus.alu_wd;
        end
    end

    // Pointers, occupancy and the registered write port.
    always_ff @(posedge clk_20M) begin
        if (rst_n) begin
            rd_q   <= 1'b0;
            rd_n_q <= 5'd0;
            wd_q   <= 32'h0;
            cnt    <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (sel_any) begin
                // An x0 target still consumes its slot but writes nothing.
                if (sel_rd_n == 5'd0) begin
                    rd_q   <= 1'b0;
                    rd_n_q <= 5'd0;
                    wd_q   <= 32'h0;
                end else begin
                    rd_q   <= 1'b1;
                    rd_n_q <= sel_rd_n;
                    wd_q   <= sel_wd;
                end
            end else begin
                rd_q <= 1'b0;
            end

            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end

            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign bus.rd   = rd_q;
    assign bus.rd_n = rd_n_q;
    assign bus.wd   = wd_q;

endmodule

// File: tb/tb_gr_wb_stage.sv
// Directed bench for gr_wb_stage: one task per scenario, hand-computed results.
module tb_gr_wb_stage;

    logic clk_20M = 1'b0;
    logic rst_n   = 1'b1;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    gr_wb_if bus ();

    gr_wb_stage #(.DEPTH(2)) dut (
        .clk_20M (clk_20M),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    always #25 clk_20M = ~clk_20M;

    task automatic step();
        @(posedge clk_20M);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid    = 1'b0;
        bus.alu_rd_n     = 5'd0;
        bus.alu_wd       = 32'h0;
        bus.load_valid   = 1'b0;
        bus.load_rd_n    = 5'd0;
        bus.load_funct3  = 3'b010;
        bus.load_addr_lo = 2'd0;
        bus.load_rdata   = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        n_cmp++; if (bus.rd !== 1'b0) begin n_bad++; $display("FAIL reset_rd got %h want 0", bus.rd); end
        n_cmp++; if (bus.rd_n !== 5'd0) begin n_bad++; $display("FAIL reset_rd_n got %h want 0", bus.rd_n); end
        n_cmp++; if (bus.wd !== 32'h0) begin n_bad++; $display("FAIL reset_wd got %h want 0", bus.wd); end
        n_cmp++; if (bus.alu_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %h want 1", bus.alu_ready); end
        n_cmp++; if (bus.pend_mask !== 32'h0) begin n_bad++; $display("FAIL reset_pend got %h want 0", bus.pend_mask); end
    endtask

    task automatic test_alu_alone();
        bus.alu_valid = 1'b1;
        bus.alu_rd_n  = 5'd5;
        bus.alu_wd    = 32'h1234_5678;
        step();
        idle_inputs();
        n_cmp++; if (bus.rd !== 1'b1) begin n_bad++; $display("FAIL alu_rd got %h want 1", bus.rd); end
        n_cmp++; if (bus.rd_n !== 5'd5) begin n_bad++; $display("FAIL alu_rd_n got %h want 05", bus.rd_n); end
        n_cmp++; if (bus.wd !== 32'h1234_5678) begin n_bad++; $display("FAIL alu_wd got %h want 12345678", bus.wd); end
        n_cmp++; if (bus.pend_mask !== 32'h0) begin n_bad++; $display("FAIL alu_pend got %h want 0", bus.pend_mask); end
        n_cmp++; if (bus.alu_ready !== 1'b1) begin n_bad++; $display("FAIL alu_ready got %h want 1", bus.alu_ready); end
        step();
        n_cmp++; if (bus.rd !== 1'b0) begin n_bad++; $display("FAIL alu_idle_rd got %h want 0", bus.rd); end
        n_cmp++; if (bus.rd_n !== 5'd5 || bus.wd !== 32'h1234_5678) begin
            n_bad++; $display("FAIL alu_idle_hold got %h/%h want 05/12345678", bus.rd_n, bus.wd);
        end
    endtask

    task automatic test_collision();
        bus.load_valid  = 1'b1;
        bus.load_funct3 = 3'b010;
        bus.load_rd_n   = 5'd3;
        bus.load_rdata  = 32'hAABB_CCDD;
        bus.alu_valid   = 1'b1;
        bus.alu_rd_n    = 5'd7;
        bus.alu_wd      = 32'h11;
        step();
        n_cmp++; if (bus.rd !== 1'b1 || bus.rd_n !== 5'd3 || bus.wd !== 32'hAABB_CCDD) begin
            n_bad++; $display("FAIL coll_n1 got %h/%h/%h want 1/03/aabbccdd", bus.rd, bus.rd_n, bus.wd);
        end
        n_cmp++; if (bus.pend_mask !== 32'h0000_0080) begin n_bad++; $display("FAIL coll_pend1 got %h want 00000080", bus.pend_mask); end
        bus.load_valid = 1'b0;
        bus.alu_rd_n   = 5'd8;
        bus.alu_wd     = 32'h22;
        step();
        bus.alu_valid = 1'b0;
        n_cmp++; if (bus.rd !== 1'b1 || bus.rd_n !== 5'd7 || bus.wd !== 32'h11) begin
            n_bad++; $display("FAIL coll_n2 got %h/%h/%h want 1/07/00000011", bus.rd, bus.rd_n, bus.wd);
        end
        n_cmp++; if (bus.pend_mask !== 32'h0000_0100) begin n_bad++; $display("FAIL coll_pend2 got %h want 00000100", bus.pend_mask); end
        step();
        n_cmp++; if (bus.rd !== 1'b1 || bus.rd_n !== 5'd8 || bus.wd !== 32'h22) begin
            n_bad++; $display("FAIL coll_n3 got %h/%h/%h want 1/08/00000022", bus.rd, bus.rd_n, bus.wd);
        end
        n_cmp++; if (bus.pend_mask !== 32'h0) begin n_bad++; $display("FAIL coll_pend3 got %h want 0", bus.pend_mask); end
        step();
        n_cmp++; if (bus.rd !== 1'b0) begin n_bad++; $display("FAIL coll_idle got %h want 0", bus.rd); end
    endtask

    task automatic test_fifo_full();
        // Per cycle: inputs, then the registered write and ready/pend after the edge.
        logic        lv  [7] = '{1, 1, 1, 0, 0, 0, 0};
        logic [4:0]  lrn [7] = '{20, 21, 22, 0, 0, 0, 0};
        logic [31:0] lrd [7] = '{32'h100, 32'h200, 32'h300, 0, 0, 0, 0};
        logic        av  [7] = '{1, 1, 1, 1, 1, 0, 0};
        logic [4:0]  arn [7] = '{10, 11, 12, 12, 12, 0, 0};
        logic [31:0] awd [7] = '{32'hA1, 32'hA2, 32'hA3, 32'hA3, 32'hA3, 0, 0};
        logic        e_rd  [7] = '{1, 1, 1, 1, 1, 1, 0};
        logic [4:0]  e_rn  [7] = '{20, 21, 22, 10, 11, 12, 12};
        logic [31:0] e_wd  [7] = '{32'h100, 32'h200, 32'h300, 32'hA1, 32'hA2, 32'hA3, 32'hA3};
        logic        e_rdy [7] = '{1, 0, 0, 1, 1, 1, 1};
        logic [31:0] e_pm  [7] = '{32'h400, 32'hC00, 32'hC00, 32'h800, 32'h1000, 32'h0, 32'h0};
        for (int i = 0; i < 7; i++) begin
            bus.load_valid  = lv[i];
            bus.load_funct3 = 3'b010;
            bus.load_rd_n   = lrn[i];
            bus.load_rdata  = lrd[i];
            bus.alu_valid   = av[i];
            bus.alu_rd_n    = arn[i];
            bus.alu_wd      = awd[i];
            step();
            n_cmp++; if (bus.rd !== e_rd[i] || (e_rd[i] && (bus.rd_n !== e_rn[i] || bus.wd !== e_wd[i]))) begin
                n_bad++; $display("FAIL full_write[%0d] got %h/%h/%h want %h/%h/%h", i, bus.rd, bus.rd_n, bus.wd, e_rd[i], e_rn[i], e_wd[i]);
            end
            n_cmp++; if (bus.alu_ready !== e_rdy[i]) begin
                n_bad++; $display("FAIL full_ready[%0d] got %h want %h", i, bus.alu_ready, e_rdy[i]);
            end
            n_cmp++; if (bus.pend_mask !== e_pm[i]) begin
                n_bad++; $display("FAIL full_pend[%0d] got %h want %h", i, bus.pend_mask, e_pm[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3 [9] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b010, 3'b011, 3'b000, 3'b100};
        logic [1:0]  al [9] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd3, 2'd3, 2'd1, 2'd2, 2'd3};
        logic [31:0] ex [9] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01,
                                32'hFFFF_80FF, 32'h80FF_7F01, 32'h80FF_7F01, 32'hFFFF_FFFF,
                                32'h0000_0080};
        bus.load_rdata = 32'h80FF_7F01;
        bus.load_rd_n  = 5'd9;
        for (int i = 0; i < 9; i++) begin
            bus.load_valid   = 1'b1;
            bus.load_funct3  = f3[i];
            bus.load_addr_lo = al[i];
            step();
            n_cmp++; if (bus.rd !== 1'b1 || bus.rd_n !== 5'd9 || bus.wd !== ex[i]) begin
                n_bad++; $display("FAIL ldext[%0d] f3=%b lo=%0d got %h/%h/%h want 1/09/%h", i, f3[i], al[i], bus.rd, bus.rd_n, bus.wd, ex[i]);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_x0();
        bus.alu_valid = 1'b1;
        bus.alu_rd_n  = 5'd0;
        bus.alu_wd    = 32'h55;
        step();
        idle_inputs();
        n_cmp++; if (bus.rd !== 1'b0 || bus.rd_n !== 5'd0 || bus.wd !== 32'h0) begin
            n_bad++; $display("FAIL x0_write got %h/%h/%h want 0/00/00000000", bus.rd, bus.rd_n, bus.wd);
        end
        n_cmp++; if (bus.alu_ready !== 1'b1 || bus.pend_mask !== 32'h0) begin
            n_bad++; $display("FAIL x0_state got %h/%h want 1/00000000", bus.alu_ready, bus.pend_mask);
        end
    endtask

    task automatic test_reset_mid_queue();
        bus.load_valid  = 1'b1;
        bus.load_funct3 = 3'b010;
        bus.load_rd_n   = 5'd1;
        bus.load_rdata  = 32'h1;
        bus.alu_valid   = 1'b1;
        bus.alu_rd_n    = 5'd13;
        bus.alu_wd      = 32'hD;
        step();
        bus.load_rd_n  = 5'd2;
        bus.load_rdata = 32'h2;
        bus.alu_rd_n   = 5'd14;
        bus.alu_wd     = 32'hE;
        step();
        idle_inputs();
        n_cmp++; if (bus.alu_ready !== 1'b0 || bus.pend_mask !== 32'h0000_6000) begin
            n_bad++; $display("FAIL midq_fill got %h/%h want 0/00006000", bus.alu_ready, bus.pend_mask);
        end
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
        n_cmp++; if (bus.rd !== 1'b0 || bus.rd_n !== 5'd0 || bus.wd !== 32'h0) begin
            n_bad++; $display("FAIL midq_reset_out got %h/%h/%h want 0/00/00000000", bus.rd, bus.rd_n, bus.wd);
        end
        n_cmp++; if (bus.alu_ready !== 1'b1 || bus.pend_mask !== 32'h0) begin
            n_bad++; $display("FAIL midq_reset_state got %h/%h want 1/00000000", bus.alu_ready, bus.pend_mask);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (bus.rd !== 1'b0) begin
                n_bad++; $display("FAIL midq_drained[%0d] got rd=%h rd_n=%h want rd=0", i, bus.rd, bus.rd_n);
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_alu_alone();
        test_collision();
        test_fifo_full();
        test_load_ext();
        test_x0();
        test_reset_mid_queue();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
